mem_access: RTL and testbench

Memory-access stage of the cqu_mips five-stage pipeline. It sits directly downstream of `execute` and upstream of write-back. It latches the execute outputs into its own stage register and drives a req/ack data-memory port. It also performs byte-lane alignment for LB/LBU/LH/LHU/LW/SB/SH/SW, detects misaligned addresses, and presents a registered write-back bundle. Multi-cycle memory latency is absorbed by an internal FSM, which asserts `mem_stall` to freeze the upstream stages.

---
 rtl/mem_access.sv | 169 ++++++++++++++++
 tb/tb_mem_access.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: latches execute outputs, runs the req/ack data-memory
// handshake, aligns load/store byte lanes and registers the write-back bundle.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_inst,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_write_reg,
  output logic        wb_reg_write,
  output logic [31:0] wb_inst,
  output logic        addr_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] alu_p1, addr_p1, sd_p1, inst_p1;
  logic        rd_p1, wr_p1, m2r_p1, rw_p1;
  logic [4:0]  wreg_p1;
  logic [31:0] rbuf;

  logic [5:0]  op;
  logic        is_byte, is_half, is_signed, memop, misalign, access, adv;
  logic [31:0] rdata_sel, result_p1;

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic byte_op, input logic half_op,
                                             input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (byte_op)      return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    else if (half_op) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
    else              return word;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] off, input logic byte_op,
                                          input logic half_op);
    if (byte_op)      return 4'b0001 << off;
    else if (half_op) return off[1] ? 4'b1100 : 4'b0011;
    else              return 4'b1111;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] sd, input logic byte_op,
                                              input logic half_op);
    if (byte_op)      return {4{sd[7:0]}};
    else if (half_op) return {2{sd[15:0]}};
    else              return sd;
  endfunction

  always_comb begin
    op        = inst_p1[31:26];
    is_byte   = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    is_half   = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_signed = (op == OP_LB) || (op == OP_LH);
    memop     = rd_p1 | wr_p1;
    misalign  = memop & ((is_half & addr_p1[0]) | (~is_byte & ~is_half & (|addr_p1[1:0])));
    access    = memop & ~misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dmem_req = 1'b0;
    case (state)
      IDLE: if (access) begin
        dmem_req = 1'b1;
        if (dmem_ack) state_nx = stall_in ? DONE : IDLE;
        else          state_nx = BUSY;
      end
      BUSY: begin
        dmem_req = access;
        if (dmem_ack) state_nx = stall_in ? DONE : IDLE;
      end
      DONE: if (!stall_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_stall  = dmem_req & ~dmem_ack;
  assign adv        = ~stall_in & ~mem_stall;
  assign dmem_we    = wr_p1;
  assign dmem_addr  = {addr_p1[31:2], 2'b00};
  assign dmem_be    = memop ? (wr_p1 ? store_be(addr_p1[1:0], is_byte, is_half) : 4'hF) : 4'h0;
  assign dmem_wdata = store_lanes(sd_p1, is_byte, is_half);
  assign rdata_sel  = (dmem_req & dmem_ack) ? dmem_rdata : rbuf;
  assign result_p1  = m2r_p1 ? load_align(rdata_sel, addr_p1[1:0], is_byte, is_half, is_signed)
                             : alu_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rbuf <= '0;
    else if (dmem_req && dmem_ack)  rbuf <= dmem_rdata;
  end

  // EX -> M stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_p1  <= '0;
      addr_p1 <= '0;
      sd_p1   <= '0;
      inst_p1 <= '0;
      rd_p1   <= 1'b0;
      wr_p1   <= 1'b0;
      m2r_p1  <= 1'b0;
      rw_p1   <= 1'b0;
      wreg_p1 <= '0;
    end else if (adv) begin
      alu_p1  <= ex_alu_result;
      addr_p1 <= ex_mem_addr;
      sd_p1   <= ex_store_data;
      inst_p1 <= ex_inst;
      rd_p1   <= ex_mem_read;
      wr_p1   <= ex_mem_write;
      m2r_p1  <= ex_mem_to_reg;
      rw_p1   <= ex_reg_write;
      wreg_p1 <= ex_write_reg;
    end
  end

  // M -> W stage register; a memory wait without a downstream hold inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_result    <= '0;
      wb_write_reg <= '0;
      wb_reg_write <= 1'b0;
      wb_inst      <= '0;
      addr_err     <= 1'b0;
    end else if (adv) begin
      wb_result    <= result_p1;
      wb_write_reg <= wreg_p1;
      wb_reg_write <= rw_p1 & ~misalign;
      wb_inst      <= inst_p1;
      addr_err     <= misalign;
    end else if (!stall_in) begin
      wb_reg_write <= 1'b0;
      addr_err     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by a random
// instruction stream checked against a transaction-level reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0;
  logic [31:0] ex_alu_result = '0, ex_mem_addr = '0, ex_store_data = '0, ex_inst = '0;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0;
  logic [4:0]  ex_write_reg = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, mem_stall, wb_reg_write, addr_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, wb_result, wb_inst;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_write_reg;

  mem_access dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .ex_alu_result(ex_alu_result), .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data), .ex_inst(ex_inst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .wb_result(wb_result), .wb_write_reg(wb_write_reg),
    .wb_reg_write(wb_reg_write), .wb_inst(wb_inst), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_ALU = 6'h00, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                         OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
                         OP_SW = 6'h2B, OP_XRD = 6'h0F, OP_XWR = 6'h3F;

  typedef struct {
    logic [31:0] alu, addr, sd, inst, rdata;
    logic        rd, wr, m2r, rw;
    logic [4:0]  wreg;
    int          waits;
  } instr_t;

  int n_vec = 0, n_err = 0;

  instr_t      pend, m;
  int          spent;
  bit          done, took;
  logic [31:0] rbuf_m, w_res, w_inst;
  logic [4:0]  w_reg;
  logic        w_rw, w_err;
  logic        a_req, a_ack, a_stl, a_stall;
  int          stalls, bursts, bubbles;
  logic        prev_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (access rules as plain arithmetic) ----------------
  function automatic int sz(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit is_mem(input instr_t x);
    return x.rd | x.wr;
  endfunction

  function automatic bit bad(input instr_t x);
    return is_mem(x) && ((int'(x.addr[1:0]) % sz(x.inst[31:26])) != 0);
  endfunction

  function automatic int lane(input instr_t x);
    int s = sz(x.inst[31:26]);
    return (int'(x.addr[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] exp_be(input instr_t x);
    if (!is_mem(x)) return 4'h0;
    if (!x.wr)      return 4'hF;
    return 4'(((1 << sz(x.inst[31:26])) - 1) << lane(x));
  endfunction

  function automatic logic [31:0] exp_wdata(input instr_t x);
    logic [31:0] w;
    int s = sz(x.inst[31:26]);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = x.sd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input instr_t x, input logic [31:0] word);
    logic [31:0] v, mask;
    int s = sz(x.inst[31:26]);
    v = word >> (8 * lane(x));
    if (s == 4) return v;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = v & mask;
    if ((x.inst[31:26] == OP_LB || x.inst[31:26] == OP_LH) && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] alu, input logic [4:0] wreg, input logic rw,
                                input int waits, input logic [31:0] rdata);
    instr_t x;
    x.alu = alu; x.addr = addr; x.sd = sd; x.wreg = wreg; x.waits = waits; x.rdata = rdata;
    x.inst = {op, addr[25:0]};
    x.rd  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
            (op == OP_LHU) || (op == OP_XRD);
    x.wr  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_XWR);
    x.m2r = x.rd;
    x.rw  = x.rd ? 1'b1 : (x.wr ? 1'b0 : rw);
    return x;
  endfunction

  function automatic instr_t nop();
    return mk(OP_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0);
  endfunction

  function automatic instr_t rand_instr();
    logic [5:0]  op;
    logic [31:0] addr;
    case ($urandom_range(0, 10))
      0: op = OP_LB;  1: op = OP_LH;  2: op = OP_LW;  3: op = OP_LBU; 4: op = OP_LHU;
      5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;  8: op = OP_XRD; 9: op = OP_XWR;
      default: op = OP_ALU;
    endcase
    addr = $urandom;
    if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
    return mk(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom);
  endfunction

  // ---------------- cycle engine ----------------
  // phase_a: drive inputs just after the edge, check request-side outputs at negedge
  task automatic phase_a(input logic stall);
    a_stall       = stall;
    stall_in      = stall;
    ex_alu_result = pend.alu;  ex_mem_addr  = pend.addr; ex_store_data = pend.sd;
    ex_inst       = pend.inst; ex_mem_read  = pend.rd;   ex_mem_write  = pend.wr;
    ex_mem_to_reg = pend.m2r;  ex_reg_write = pend.rw;   ex_write_reg  = pend.wreg;
    a_req = is_mem(m) && !bad(m) && !done;
    a_ack = a_req && (spent >= m.waits);
    a_stl = a_req && !a_ack;
    dmem_ack   = a_req ? a_ack : ($urandom_range(0, 3) == 0);
    dmem_rdata = a_ack ? m.rdata : $urandom;
    @(negedge clk);
    chk("dmem_req", dmem_req, a_req);
    chk("mem_stall", mem_stall, a_stl);
    if (a_req) begin
      chk("dmem_addr", dmem_addr, {m.addr[31:2], 2'b00});
      chk("dmem_we", dmem_we, m.wr);
      chk("dmem_be", dmem_be, exp_be(m));
      if (m.wr) chk("dmem_wdata", dmem_wdata, exp_wdata(m));
    end
  endtask

  // phase_b: advance the model across the edge and check the write-back bundle
  task automatic phase_b();
    logic [31:0] d;
    took = 0;
    d = a_ack ? m.rdata : rbuf_m;
    if (a_ack) begin
      rbuf_m = m.rdata;
      if (a_stall) done = 1;
    end
    if (!a_stall && !a_stl) begin
      w_res  = m.m2r ? exp_load(m, d) : m.alu;
      w_reg  = m.wreg;
      w_rw   = m.rw && !bad(m);
      w_inst = m.inst;
      w_err  = bad(m);
      m = pend; spent = 0; done = 0; took = 1;
    end else begin
      if (!a_stall) begin w_rw = 1'b0; w_err = 1'b0; end
      if (a_stl) spent++;
    end
    @(posedge clk); #1;
    chk("wb_result", wb_result, w_res);
    chk("wb_write_reg", wb_write_reg, w_reg);
    chk("wb_reg_write", wb_reg_write, w_rw);
    chk("wb_inst", wb_inst, w_inst);
    chk("addr_err", addr_err, w_err);
  endtask

  task automatic cyc(input logic stall);
    phase_a(stall);
    phase_b();
  endtask

  task automatic do_reset();
    rst = 1'b1; dmem_ack = 1'b0; stall_in = 1'b0;
    #1;
    chk("rst_req", dmem_req, 0);       chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);         chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);   chk("rst_stall", mem_stall, 0);
    chk("rst_wb_result", wb_result, 0); chk("rst_wb_reg", wb_write_reg, 0);
    chk("rst_wb_rw", wb_reg_write, 0); chk("rst_wb_inst", wb_inst, 0);
    chk("rst_addr_err", addr_err, 0);
    m = nop(); pend = nop(); spent = 0; done = 0; rbuf_m = '0;
    w_res = '0; w_reg = '0; w_rw = 1'b0; w_inst = '0; w_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // ALU pass-through
    pend = mk(OP_ALU, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 32'h0);
    cyc(0); pend = nop(); cyc(0);
    chk("alu_result", wb_result, 32'h1234);
    chk("alu_wreg", wb_write_reg, 5);
    chk("alu_rw", wb_reg_write, 1);

    // LB sign-extend and LBU zero-extend, zero-wait
    pend = mk(OP_LB, 32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 0, 32'h80FF7F01);
    cyc(0); pend = nop();
    phase_a(0); chk("lb_addr", dmem_addr, 32'h100); chk("lb_nostall", mem_stall, 0); phase_b();
    chk("lb_result", wb_result, 32'hFFFFFFFF);
    pend = mk(OP_LBU, 32'h103, 32'h0, 32'h0, 5'd8, 1'b1, 0, 32'h80FF7F01);
    cyc(0); pend = nop(); cyc(0);
    chk("lbu_result", wb_result, 32'h00000080);

    // Stores
    pend = mk(OP_SH, 32'h206, 32'hAAAA5678, 32'h0, 5'd0, 1'b0, 0, 32'h0);
    cyc(0); pend = nop();
    phase_a(0);
    chk("sh_be", dmem_be, 4'b1100); chk("sh_wdata", dmem_wdata, 32'h56785678); chk("sh_we", dmem_we, 1);
    phase_b();
    pend = mk(OP_SB, 32'h201, 32'h000000A5, 32'h0, 5'd0, 1'b0, 0, 32'h0);
    cyc(0); pend = nop();
    phase_a(0); chk("sb_be", dmem_be, 4'b0010); phase_b();

    // LW with three wait states, preceded by an ALU op so bubbles are visible
    pend = mk(OP_ALU, 32'h0, 32'h0, 32'h55, 5'd2, 1'b1, 0, 32'h0);
    cyc(0);
    pend = mk(OP_LW, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 3, 32'hDEADBEEF);
    cyc(0); pend = nop();
    stalls = 0; bursts = 0; bubbles = 0; prev_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      phase_a(0);
      if (mem_stall) stalls++;
      if (dmem_req && !prev_req) bursts++;
      prev_req = dmem_req;
      phase_b();
      if (took) break;
      if (wb_reg_write === 1'b0) bubbles++;
    end
    chk("lw_wait_completed", took, 1);
    chk("lw_stall_cycles", stalls, 3);
    chk("lw_req_bursts", bursts, 1);
    chk("lw_bubbles", bubbles, 3);
    chk("lw_result", wb_result, 32'hDEADBEEF);

    // Misaligned LW, then an aligned LW that must flow without a stall
    pend = mk(OP_LW, 32'h102, 32'h0, 32'h0, 5'd3, 1'b1, 0, 32'h11111111);
    cyc(0);
    pend = mk(OP_LW, 32'h104, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h22223333);
    phase_a(0); chk("mis_no_req", dmem_req, 0); phase_b();
    chk("mis_addr_err", addr_err, 1); chk("mis_rw", wb_reg_write, 0);
    pend = nop();
    phase_a(0); chk("mis_next_nostall", mem_stall, 0); phase_b();
    chk("mis_err_clear", addr_err, 0); chk("mis_next_result", wb_result, 32'h22223333);

    // Ack while held downstream: DONE, no re-issue, result from the capture buffer
    pend = mk(OP_LH, 32'h402, 32'h0, 32'h0, 5'd6, 1'b1, 1, 32'hC0DE8001);
    cyc(0); pend = nop();
    cyc(0);
    phase_a(1); chk("hold_ack_req", dmem_req, 1); phase_b();
    phase_a(1); chk("done_no_req", dmem_req, 0); phase_b();
    phase_a(0); chk("release_no_req", dmem_req, 0); phase_b();
    chk("rbuf_result", wb_result, 32'hFFFFC0DE);
    chk("rbuf_rw", wb_reg_write, 1);

    // Reset during BUSY
    pend = mk(OP_LW, 32'h500, 32'h0, 32'h0, 5'd10, 1'b1, 5, 32'h12345678);
    cyc(0); pend = nop();
    cyc(0);
    phase_a(0);
    do_reset();

    // Random stream with random downstream holds
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 4) == 0);
      if (took) pend = rand_instr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
